// File: rtl/banked_regfile_pkg.sv
// regfile_pkg: shared register indices, bank encoding and logical-to-physical mapping
// for the banked register file.
package regfile_pkg;
    localparam logic [3:0] REG_SP = 4'd13;
    localparam logic [3:0] REG_LR = 4'd14;
    localparam logic [3:0] REG_PC = 4'd15;
    localparam int PHYS_W = 5;

    typedef enum logic [1:0] {USR = 2'd0, IRQ = 2'd1, ABT = 2'd2, SVC = 2'd3} bank_e;

    // R0-R12 map 1:1, R15 sits at 13, then one SP/LR pair per bank from 14 upward
    function automatic logic [PHYS_W-1:0] phys_idx(input logic [3:0] logical, input logic [1:0] bank);
        return logical == REG_SP ? 5'd14 + {2'b0, bank, 1'b0} :
               logical == REG_LR ? 5'd15 + {2'b0, bank, 1'b0} :
               logical == REG_PC ? 5'd13 : {1'b0, logical};
    endfunction
endpackage

// File: rtl/banked_regfile_if.sv
// banked_regfile_if: mode, write, read and issue signals between the datapath and the
// banked register file.
interface banked_regfile_if #(parameter int DATA_W = 32, parameter int NUM_RD = 3);
    logic                     mode_wr_en;
    logic [1:0]               mode_in;
    logic [1:0]               mode_o;
    logic                     w_en1;
    logic [3:0]               w_addr1;
    logic [DATA_W-1:0]        w_data1;
    logic                     w_en2;
    logic [3:0]               w_addr2;
    logic [DATA_W-1:0]        w_data2;
    logic [4*NUM_RD-1:0]      rd_addr;
    logic [DATA_W*NUM_RD-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_busy;
    logic                     issue_en;
    logic [3:0]               issue_addr;

    modport master (
        output mode_wr_en, mode_in, w_en1, w_addr1, w_data1, w_en2, w_addr2, w_data2,
               rd_addr, issue_en, issue_addr,
        input  mode_o, rd_data, rd_busy
    );
    modport slave (
        input  mode_wr_en, mode_in, w_en1, w_addr1, w_data1, w_en2, w_addr2, w_data2,
               rd_addr, issue_en, issue_addr,
        output mode_o, rd_data, rd_busy
    );
endinterface

// File: rtl/banked_regfile_scoreboard.sv
// regfile_scoreboard: one busy bit per physical register; writes clear, issues set,
// and a same-cycle issue overrides a clear on the same entry.
module regfile_scoreboard import regfile_pkg::*; #(
    parameter int NPHYS = 22
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en,
    input  logic [PHYS_W-1:0] set_idx,
    input  logic              clr1_en,
    input  logic [PHYS_W-1:0] clr1_idx,
    input  logic              clr2_en,
    input  logic [PHYS_W-1:0] clr2_idx,
    output logic [NPHYS-1:0]  busy_o
);
    logic [NPHYS-1:0] busy_q, busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clr1_en) busy_d[clr1_idx] = 1'b0;
        if (clr2_en) busy_d[clr2_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else busy_q <= busy_d;
    end

    assign busy_o = busy_q;
endmodule

// File: rtl/banked_regfile.sv
// banked_regfile: R0-R15 with per-bank SP/LR, two prioritised write ports, combinational
// read ports with optional write bypass, and a busy scoreboard.
module banked_regfile import regfile_pkg::*; #(
    parameter int DATA_W    = 32,
    parameter int NUM_RD    = 3,
    parameter int NUM_BANKS = 4,
    parameter int BYPASS    = 1
) (
    input logic             clk,
    input logic             rst_n,
    banked_regfile_if.slave bus
);
    localparam int NPHYS = 14 + 2 * NUM_BANKS;
    localparam bank_e MODE_RST = NUM_BANKS == 4 ? SVC : USR;

    logic [DATA_W-1:0] regs_q [NPHYS];
    logic [DATA_W-1:0] regs_d [NPHYS];
    bank_e             mode_q, mode_d;
    logic [PHYS_W-1:0] wp1, wp2, ip;
    logic [NPHYS-1:0]  busy;

    always_comb begin
        wp1 = phys_idx(bus.w_addr1, mode_q);
        wp2 = phys_idx(bus.w_addr2, mode_q);
        ip = phys_idx(bus.issue_addr, mode_q);
        mode_d = bus.mode_wr_en && 32'(bus.mode_in) < NUM_BANKS ? bank_e'(bus.mode_in) : mode_q;
        regs_d = regs_q;
        if (bus.w_en1) regs_d[wp1] = bus.w_data1;
        if (bus.w_en2) regs_d[wp2] = bus.w_data2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MODE_RST;
            for (int k = 0; k < NPHYS; k++) regs_q[k] <= '0;
        end else begin
            mode_q <= mode_d;
            regs_q <= regs_d;
        end
    end

    regfile_scoreboard #(.NPHYS(NPHYS)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (bus.issue_en),
        .set_idx  (ip),
        .clr1_en  (bus.w_en1),
        .clr1_idx (wp1),
        .clr2_en  (bus.w_en2),
        .clr2_idx (wp2),
        .busy_o   (busy)
    );

    assign bus.mode_o = mode_q;

    // Logical address compare suffices: writes and reads share the current mode
    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [3:0]        a;
        logic [PHYS_W-1:0] p;
        logic              h1, h2;
        assign a = bus.rd_addr[4*i +: 4];
        assign p = phys_idx(a, mode_q);
        assign h1 = BYPASS != 0 && rst_n && bus.w_en1 && bus.w_addr1 == a;
        assign h2 = BYPASS != 0 && rst_n && bus.w_en2 && bus.w_addr2 == a;
        assign bus.rd_data[DATA_W*i +: DATA_W] = h2 ? bus.w_data2 : h1 ? bus.w_data1 : regs_q[p];
        assign bus.rd_busy[i] = busy[p] & ~(h1 | h2);
    end
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: directed and random checks of bypassed and non-bypassed register
// file builds against a per-bank behavioural model.
module tb_banked_regfile;
    import regfile_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mode_wr_en, w_en1, w_en2, issue_en;
    logic [1:0]  mode_in;
    logic [3:0]  w_addr1, w_addr2, issue_addr;
    logic [31:0] w_data1, w_data2;
    logic [11:0] rd_addr;

    banked_regfile_if #(.DATA_W(32), .NUM_RD(3)) ba ();
    banked_regfile_if #(.DATA_W(32), .NUM_RD(3)) bb ();

    assign ba.mode_wr_en = mode_wr_en;
    assign ba.mode_in = mode_in;
    assign ba.w_en1 = w_en1;
    assign ba.w_addr1 = w_addr1;
    assign ba.w_data1 = w_data1;
    assign ba.w_en2 = w_en2;
    assign ba.w_addr2 = w_addr2;
    assign ba.w_data2 = w_data2;
    assign ba.rd_addr = rd_addr;
    assign ba.issue_en = issue_en;
    assign ba.issue_addr = issue_addr;
    assign bb.mode_wr_en = mode_wr_en;
    assign bb.mode_in = mode_in;
    assign bb.w_en1 = w_en1;
    assign bb.w_addr1 = w_addr1;
    assign bb.w_data1 = w_data1;
    assign bb.w_en2 = w_en2;
    assign bb.w_addr2 = w_addr2;
    assign bb.w_data2 = w_data2;
    assign bb.rd_addr = rd_addr;
    assign bb.issue_en = issue_en;
    assign bb.issue_addr = issue_addr;

    banked_regfile #(.DATA_W(32), .NUM_RD(3), .NUM_BANKS(4), .BYPASS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(ba));
    banked_regfile #(.DATA_W(32), .NUM_RD(3), .NUM_BANKS(4), .BYPASS(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .bus(bb));

    int checks = 0;
    int errors = 0;

    // Model: architectural view, one R0-R15 set plus separate SP/LR per bank
    logic [31:0] m_reg [16];
    logic [31:0] m_sp [4];
    logic [31:0] m_lr [4];
    bit          b_reg [16];
    bit          b_sp [4];
    bit          b_lr [4];
    int          m_mode;

    function automatic logic [31:0] mget(logic [3:0] a, int b);
        return a == 13 ? m_sp[b] : a == 14 ? m_lr[b] : m_reg[a];
    endfunction

    function automatic bit bget(logic [3:0] a, int b);
        return a == 13 ? b_sp[b] : a == 14 ? b_lr[b] : b_reg[a];
    endfunction

    task automatic mput(logic [3:0] a, int b, logic [31:0] d);
        if (a == 13) m_sp[b] = d;
        else if (a == 14) m_lr[b] = d;
        else m_reg[a] = d;
    endtask

    task automatic bput(logic [3:0] a, int b, bit v);
        if (a == 13) b_sp[b] = v;
        else if (a == 14) b_lr[b] = v;
        else b_reg[a] = v;
    endtask

    function automatic bit hit(logic [3:0] a);
        return (w_en1 && w_addr1 == a) || (w_en2 && w_addr2 == a);
    endfunction

    function automatic logic [31:0] exp_rd(int i, bit byp);
        logic [3:0] a = rd_addr[4*i +: 4];
        if (byp && w_en2 && w_addr2 == a) return w_data2;
        if (byp && w_en1 && w_addr1 == a) return w_data1;
        return mget(a, m_mode);
    endfunction

    function automatic bit exp_bz(int i, bit byp);
        logic [3:0] a = rd_addr[4*i +: 4];
        return bget(a, m_mode) && !(byp && hit(a));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 16; k++) begin m_reg[k] = '0; b_reg[k] = 0; end
        for (int k = 0; k < 4; k++) begin m_sp[k] = '0; m_lr[k] = '0; b_sp[k] = 0; b_lr[k] = 0; end
        m_mode = 3;
    endtask

    task automatic idle();
        mode_wr_en = 0; mode_in = 0; w_en1 = 0; w_addr1 = 0; w_data1 = 0;
        w_en2 = 0; w_addr2 = 0; w_data2 = 0; issue_en = 0; issue_addr = 0;
    endtask

    task automatic tick();
        if (w_en1) begin mput(w_addr1, m_mode, w_data1); bput(w_addr1, m_mode, 0); end
        if (w_en2) begin mput(w_addr2, m_mode, w_data2); bput(w_addr2, m_mode, 0); end
        if (issue_en) bput(issue_addr, m_mode, 1);
        if (mode_wr_en && mode_in < 4) m_mode = mode_in;
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        w_en1 = 1; w_addr1 = 5; w_data1 = 32'h1234; issue_en = 1; issue_addr = 6;
        tick();
        #2;
        rst_n = 0;
        w_en1 = 1; w_addr1 = 5; w_data1 = 32'hFFFF_FFFF; issue_en = 1; issue_addr = 13;
        rd_addr = {4'd13, 4'd6, 4'd5};
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (ba.rd_data[32*i +: 32] !== 32'h0 || bb.rd_data[32*i +: 32] !== 32'h0) begin
                errors++; $display("FAIL reset_data[%0d] got %h/%h want 0", i, ba.rd_data[32*i +: 32], bb.rd_data[32*i +: 32]);
            end
        end
        checks++;
        if (ba.rd_busy !== 3'b000 || bb.rd_busy !== 3'b000) begin
            errors++; $display("FAIL reset_busy got %b/%b want 000", ba.rd_busy, bb.rd_busy);
        end
        checks++;
        if (ba.mode_o !== 2'd3 || bb.mode_o !== 2'd3) begin
            errors++; $display("FAIL reset_mode got %0d/%0d want 3", ba.mode_o, bb.mode_o);
        end
        @(posedge clk);
        #1;
        idle();
        model_reset();
        rst_n = 1;
        #1;
        checks++;
        if (bb.rd_data !== 96'h0 || bb.rd_busy !== 3'b000) begin
            errors++; $display("FAIL reset_discard got %h busy %b want 0", bb.rd_data, bb.rd_busy);
        end
    endtask

    task automatic test_collision();
        w_en1 = 1; w_addr1 = 5; w_data1 = 32'hAAAA_0001;
        w_en2 = 1; w_addr2 = 5; w_data2 = 32'hBBBB_0002;
        rd_addr = {4'd0, 4'd0, 4'd5};
        #1;
        checks++;
        if (ba.rd_data[31:0] !== 32'hBBBB_0002) begin
            errors++; $display("FAIL coll_bypass got %h want BBBB0002", ba.rd_data[31:0]);
        end
        checks++;
        if (bb.rd_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL coll_nobypass_old got %h want 0", bb.rd_data[31:0]);
        end
        tick();
        checks++;
        if (ba.rd_data[31:0] !== 32'hBBBB_0002 || bb.rd_data[31:0] !== 32'hBBBB_0002) begin
            errors++; $display("FAIL coll_stored got %h/%h want BBBB0002", ba.rd_data[31:0], bb.rd_data[31:0]);
        end
    endtask

    task automatic test_banking();
        mode_wr_en = 1; mode_in = 0;
        tick();
        w_en1 = 1; w_addr1 = 13; w_data1 = 32'h1000; w_en2 = 1; w_addr2 = 12; w_data2 = 32'hC0C0;
        tick();
        mode_wr_en = 1; mode_in = 3;
        tick();
        rd_addr = {4'd0, 4'd12, 4'd13};
        #1;
        checks++;
        if (bb.rd_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL bank3_sp_init got %h want 0", bb.rd_data[31:0]);
        end
        w_en1 = 1; w_addr1 = 13; w_data1 = 32'h2000;
        tick();
        rd_addr = {4'd0, 4'd12, 4'd13};
        #1;
        checks++;
        if (ba.rd_data[31:0] !== 32'h2000 || bb.rd_data[31:0] !== 32'h2000) begin
            errors++; $display("FAIL bank3_sp got %h/%h want 2000", ba.rd_data[31:0], bb.rd_data[31:0]);
        end
        checks++;
        if (bb.rd_data[63:32] !== 32'hC0C0) begin
            errors++; $display("FAIL bank3_r12 got %h want C0C0", bb.rd_data[63:32]);
        end
        mode_wr_en = 1; mode_in = 0;
        tick();
        rd_addr = {4'd0, 4'd12, 4'd13};
        #1;
        checks++;
        if (ba.rd_data[31:0] !== 32'h1000 || bb.rd_data[31:0] !== 32'h1000) begin
            errors++; $display("FAIL bank0_sp got %h/%h want 1000", ba.rd_data[31:0], bb.rd_data[31:0]);
        end
        checks++;
        if (bb.rd_data[63:32] !== 32'hC0C0) begin
            errors++; $display("FAIL bank0_r12 got %h want C0C0", bb.rd_data[63:32]);
        end
    endtask

    task automatic test_mode_timing();
        mode_wr_en = 1; mode_in = 1; w_en1 = 1; w_addr1 = 14; w_data1 = 32'h55;
        tick();
        rd_addr = {4'd0, 4'd0, 4'd14};
        #1;
        checks++;
        if (ba.mode_o !== 2'd1) begin
            errors++; $display("FAIL mode_next got %0d want 1", ba.mode_o);
        end
        checks++;
        if (bb.rd_data[31:0] !== 32'h0) begin
            errors++; $display("FAIL bank1_lr got %h want 0", bb.rd_data[31:0]);
        end
        mode_wr_en = 1; mode_in = 0;
        tick();
        rd_addr = {4'd0, 4'd0, 4'd14};
        #1;
        checks++;
        if (bb.rd_data[31:0] !== 32'h55) begin
            errors++; $display("FAIL bank0_lr got %h want 55", bb.rd_data[31:0]);
        end
    endtask

    task automatic test_scoreboard();
        rd_addr = {4'd0, 4'd0, 4'd3};
        issue_en = 1; issue_addr = 3;
        tick();
        rd_addr = {4'd0, 4'd0, 4'd3};
        #1;
        checks++;
        if (ba.rd_busy[0] !== 1'b1 || bb.rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_issue got %b/%b want 1", ba.rd_busy[0], bb.rd_busy[0]);
        end
        w_en1 = 1; w_addr1 = 3; w_data1 = 32'h7;
        #1;
        checks++;
        if (ba.rd_busy[0] !== 1'b0 || ba.rd_data[31:0] !== 32'h7) begin
            errors++; $display("FAIL sb_bypass busy %b data %h want 0/7", ba.rd_busy[0], ba.rd_data[31:0]);
        end
        checks++;
        if (bb.rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_nobypass_busy got %b want 1", bb.rd_busy[0]);
        end
        tick();
        rd_addr = {4'd0, 4'd0, 4'd3};
        #1;
        checks++;
        if (ba.rd_busy[0] !== 1'b0 || bb.rd_busy[0] !== 1'b0 || bb.rd_data[31:0] !== 32'h7) begin
            errors++; $display("FAIL sb_clear busy %b/%b data %h want 0/0/7", ba.rd_busy[0], bb.rd_busy[0], bb.rd_data[31:0]);
        end
        issue_en = 1; issue_addr = 3; w_en2 = 1; w_addr2 = 3; w_data2 = 32'h9;
        tick();
        rd_addr = {4'd0, 4'd0, 4'd3};
        #1;
        checks++;
        if (ba.rd_busy[0] !== 1'b1 || bb.rd_busy[0] !== 1'b1) begin
            errors++; $display("FAIL sb_set_wins got %b/%b want 1", ba.rd_busy[0], bb.rd_busy[0]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            w_en1 = 1'($urandom); w_addr1 = 4'($urandom); w_data1 = $urandom;
            w_en2 = 1'($urandom); w_addr2 = ($urandom_range(0, 3) == 0) ? w_addr1 : 4'($urandom);
            w_data2 = $urandom;
            issue_en = 1'($urandom); issue_addr = 4'($urandom_range(10, 15));
            mode_wr_en = ($urandom_range(0, 7) == 0); mode_in = 2'($urandom);
            for (int i = 0; i < 3; i++) begin
                int s = $urandom_range(0, 2);
                rd_addr[4*i +: 4] = s == 0 ? w_addr1 : s == 1 ? w_addr2 : 4'($urandom_range(9, 15));
            end
            #1;
            checks++;
            if (ba.mode_o !== 2'(m_mode) || bb.mode_o !== 2'(m_mode)) begin
                errors++; $display("FAIL rnd_mode n=%0d got %0d/%0d want %0d", n, ba.mode_o, bb.mode_o, m_mode);
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (ba.rd_data[32*i +: 32] !== exp_rd(i, 1)) begin
                    errors++; $display("FAIL rnd_byp_data n=%0d p=%0d got %h want %h", n, i, ba.rd_data[32*i +: 32], exp_rd(i, 1));
                end
                checks++;
                if (bb.rd_data[32*i +: 32] !== exp_rd(i, 0)) begin
                    errors++; $display("FAIL rnd_raw_data n=%0d p=%0d got %h want %h", n, i, bb.rd_data[32*i +: 32], exp_rd(i, 0));
                end
                checks++;
                if (ba.rd_busy[i] !== exp_bz(i, 1)) begin
                    errors++; $display("FAIL rnd_byp_busy n=%0d p=%0d got %b want %b", n, i, ba.rd_busy[i], exp_bz(i, 1));
                end
                checks++;
                if (bb.rd_busy[i] !== exp_bz(i, 0)) begin
                    errors++; $display("FAIL rnd_raw_busy n=%0d p=%0d got %b want %b", n, i, bb.rd_busy[i], exp_bz(i, 0));
                end
            end
            tick();
        end
    endtask

    initial begin
        idle();
        rd_addr = '0;
        model_reset();
        #12;
        rst_n = 1;
        @(posedge clk);
        #1;
        test_reset();
        test_collision();
        test_banking();
        test_mode_timing();
        test_scoreboard();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/banked_regfile.md
# banked_regfile

Parametrised successor to the CPU's 16-entry register file. Provides DATA_W-wide architectural registers R0–R15 with per-mode banked copies of R13 (SP) and R14 (LR), NUM_RD combinational read ports, two write ports with fixed priority, optional write-to-read bypass, and a per-register busy scoreboard. It sits between decode (read/issue) and writeback (write/clear) in the datapath.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- NUM_RD, 3, number of read ports (A, B, shift, …)
- NUM_BANKS, 4, SP/LR banks; 1..4; bank 0 = user
- BYPASS, 1, 1 = same-cycle write data forwarded to reads

Ports:
- Single clock `clk`; reset `rst_n` is asynchronous and active-low.
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mode_wr_en  in  1  load new bank select
- mode_in  in  2  new bank index
- mode_o  out  2  current bank index
- w_en1 / w_addr1 / w_data1  in  1/4/DATA_W  write port 1
- w_en2 / w_addr2 / w_data2  in  1/4/DATA_W  write port 2 (priority)
- rd_addr  in  4*NUM_RD  packed read addresses, port i at [4i+3:4i]
- rd_data  out  DATA_W*NUM_RD  packed read data
- rd_busy  out  NUM_RD  busy flag per read port
- issue_en / issue_addr  in  1/4  mark destination register busy

## Operation
- Physical storage: 14 unbanked (R0–R12, R15) + 2*NUM_BANKS banked entries (R13/R14 per bank). Logical-to-physical mapping uses the current mode for R13/R14 only.
- Reads combinational through mapping. BYPASS=1: if w_enX and w_addrX equals rd_addr[i], rd_data[i] = w_dataX (port 2 wins if both match). BYPASS=0: registered value only.
- Writes on rising edge; both ports to same address → w_data2 stored.
- Mode: mode_wr_en loads mode_in at the edge. Reads, writes, issues in the same cycle use the old mode. mode_in ≥ NUM_BANKS → ignored, mode unchanged.
- Scoreboard: one busy bit per physical entry. issue_en sets busy for mapped issue_addr; a write to a physical entry clears it. Same-cycle set and clear on same entry → busy stays set (new producer wins).
- rd_busy[i] = busy of mapped entry; with BYPASS=1 it reads 0 when a same-cycle write hits that entry and no issue targets it in the same cycle… combinationally only the write term applies: rd_busy = busy & ~write_hit. BYPASS=0: raw busy bit.

## Timing
- Reset (async assert, sync-safe deassert by design upstream): all registers 0, all busy bits 0, mode_o = 2'd3 if NUM_BANKS = 4 else 2'd0 (supervisor where present). rd_data reflects 0s during reset.
- Read latency 0 cycles; write visible to non-bypassed reads next cycle; mode change visible next cycle.
- Reset mid-operation: pending writes and issues in that cycle are discarded.

## Structure
- Package `regfile_pkg`: REG_SP=13, REG_LR=14, REG_PC=15, bank index enum (USR=0, IRQ=1, ABT=2, SVC=3), function `phys_idx(logical, bank)` returning physical index.
- One sub-module natural: `regfile_scoreboard` (busy bits, set/clear priority). Storage, mapping and bypass in top.

## Test plan
- Reset: drive rst_n=0 mid-cycle → all rd_data=0, rd_busy=0, mode_o=3 with NUM_BANKS=4.
- Dual write collision: w_addr1=w_addr2=5, data 0xAAAA_0001/0xBBBB_0002 → next cycle R5 reads 0xBBBB_0002; with BYPASS=1 same-cycle read also 0xBBBB_0002.
- Banking: mode 0 write R13=0x1000; switch to 3, write R13=0x2000; read R13 = 0x2000; switch to 0 → R13 = 0x1000; R12 unaffected across modes.
- Mode timing: same cycle mode_wr_en(0→1) and write R14=0x55 → value lands in bank 0, bank 1 R14 still 0.
- Scoreboard: issue R3 → rd_busy=1 next cycle; write R3=7 → busy cleared next cycle, BYPASS=1 shows busy=0 and data 7 in write cycle; simultaneous issue+write R3 → busy remains 1.
- BYPASS=0 build: same-cycle read of written address returns old value; new value next cycle.
